// File: rtl/skein_pkg.sv
// Shared Skein/Threefish constants: word type, MIX rotation tables and word
// permutations for the 256- and 512-bit block variants.
package skein_pkg;

  typedef logic [63:0] word_t;

  localparam logic [5:0] ROT512 [8][4] = '{
    '{6'd46, 6'd36, 6'd19, 6'd37},
    '{6'd33, 6'd27, 6'd14, 6'd42},
    '{6'd17, 6'd49, 6'd36, 6'd39},
    '{6'd44, 6'd9,  6'd54, 6'd56},
    '{6'd39, 6'd30, 6'd34, 6'd24},
    '{6'd13, 6'd50, 6'd10, 6'd17},
    '{6'd25, 6'd29, 6'd39, 6'd43},
    '{6'd8,  6'd35, 6'd56, 6'd22}
  };

  localparam logic [5:0] ROT256 [8][2] = '{
    '{6'd14, 6'd16},
    '{6'd52, 6'd57},
    '{6'd23, 6'd40},
    '{6'd5,  6'd37},
    '{6'd25, 6'd33},
    '{6'd46, 6'd12},
    '{6'd58, 6'd22},
    '{6'd32, 6'd32}
  };

  localparam int PI512 [8] = '{2, 1, 4, 7, 6, 5, 0, 3};
  localparam int PI256 [4] = '{0, 3, 2, 1};

  function automatic logic [5:0] rot_amt(input int nw, input logic [2:0] d, input int j);
    logic [1:0] jj;
    jj = j[1:0];
    if (nw == 8) return ROT512[d][jj];
    else         return ROT256[d][jj[0]];
  endfunction

  function automatic int pi_idx(input int nw, input int i);
    if (nw == 8) return PI512[i % 8];
    else         return PI256[i % 4];
  endfunction

endpackage

// File: rtl/threefish_mix.sv
// Threefish MIX on one word pair: y0 = x0 + x1, y1 = rotl(x1, rot) ^ y0.
module threefish_mix
  import skein_pkg::*;
(
  input  word_t      x0,
  input  word_t      x1,
  input  logic [5:0] rot,
  output word_t      y0,
  output word_t      y1
);

  logic [127:0] dbl;

  // Rotating via a doubled word avoids the shift-by-64 corner at rot == 0.
  assign dbl = {x1, x1} << rot;
  assign y0  = x0 + x1;
  assign y1  = dbl[127:64] ^ y0;

endmodule

// File: rtl/threefish_round_engine.sv
// Iterative Threefish round engine: one MIX+permute round per clock,
// ROUNDS rounds per block, valid/ready on both sides.
module threefish_round_engine
  import skein_pkg::*;
#(
  parameter int NW     = 8,
  parameter int ROUNDS = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [NW*64-1:0] words_i,
  input  logic [2:0]       round_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [NW*64-1:0] words_o,
  output logic             busy_o
);

  if (!(NW == 4 || NW == 8)) begin : g_bad_nw
    $error("threefish_round_engine: NW must be 4 or 8");
  end
  if (ROUNDS < 1 || ROUNDS > 8) begin : g_bad_rounds
    $error("threefish_round_engine: ROUNDS must be in 1..8");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q;
  logic [NW*64-1:0] blk_q;
  logic [2:0]       d_q;
  logic [2:0]       cnt_q;

  word_t            e   [NW];
  logic [NW*64-1:0] nxt;
  logic             accept;

  for (genvar j = 0; j < NW / 2; j++) begin : g_mix
    threefish_mix u_mix (
      .x0  (blk_q[64*(2*j)   +: 64]),
      .x1  (blk_q[64*(2*j+1) +: 64]),
      .rot (rot_amt(NW, d_q, j)),
      .y0  (e[2*j]),
      .y1  (e[2*j+1])
    );
  end

  for (genvar i = 0; i < NW; i++) begin : g_perm
    assign nxt[64*i +: 64] = e[pi_idx(NW, i)];
  end

  // out_ready_i feeds in_ready_o combinationally so DONE can hand off to RUN with no bubble.
  assign in_ready_o  = (state_q == IDLE) || (state_q == DONE && out_ready_i);
  assign accept      = in_valid_i && in_ready_o;
  assign out_valid_o = (state_q == DONE);
  assign busy_o      = (state_q != IDLE);
  assign words_o     = blk_q;

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples pre-edge values and the block order never matters.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      blk_q   <= '0;
      d_q     <= '0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (accept) begin
            blk_q   <= words_i;
            d_q     <= round_i;
            cnt_q   <= '0;
            state_q <= RUN;
          end else if (state_q == DONE && out_ready_i) begin
            state_q <= IDLE;
          end
        end
        RUN: begin
          blk_q <= nxt;
          d_q   <= d_q + 3'd1;
          cnt_q <= cnt_q + 3'd1;
          if (cnt_q == 3'(ROUNDS - 1)) state_q <= DONE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
